// File: rtl/surf_cin_pkg.sv
// Shared types and default word constants for the SURF CIN framer.
// S_PAR exists only when CIN_FRAME_PARITY_EN is defined.
package surf_cin_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAIN,
    S_RUN,
    S_HDR,
`ifdef CIN_FRAME_PARITY_EN
    S_PAR,
`endif
    S_DATA
  } cin_state_t;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_TRAIN = 2'd1;
  localparam logic [1:0] MODE_RUN   = 2'd2;

  localparam int unsigned DEF_WORD_WIDTH = 6;
  localparam logic [DEF_WORD_WIDTH-1:0] DEF_TRAIN_PATTERN = 6'b011001;
  localparam logic [DEF_WORD_WIDTH-1:0] DEF_IDLE_WORD     = 6'b000000;
  localparam logic [DEF_WORD_WIDTH-1:0] DEF_HDR_WORD      = 6'b111000;
  localparam logic [DEF_WORD_WIDTH-1:0] DEF_SYNC_WORD     = 6'b101010;

  // Steady state selected by a mode field (3 aliases idle).
  function automatic cin_state_t mode_state(input logic [1:0] m);
    case (m)
      MODE_TRAIN: return S_TRAIN;
      MODE_RUN:   return S_RUN;
      default:    return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/surf_cin_chan.sv
// One CIN channel: mode FSM, command payload register and output word mux.
// CIN_FRAME_PARITY_EN appends an XOR parity word to every frame.
module surf_cin_chan
  import surf_cin_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 6,
  parameter int unsigned CMD_WORDS  = 4,
  parameter logic [WORD_WIDTH-1:0] TRAIN_PATTERN = WORD_WIDTH'(DEF_TRAIN_PATTERN),
  parameter logic [WORD_WIDTH-1:0] IDLE_WORD     = WORD_WIDTH'(DEF_IDLE_WORD),
  parameter logic [WORD_WIDTH-1:0] HDR_WORD      = WORD_WIDTH'(DEF_HDR_WORD),
  parameter logic [WORD_WIDTH-1:0] SYNC_WORD     = WORD_WIDTH'(DEF_SYNC_WORD)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      mode,
  input  logic [CMD_WORDS*WORD_WIDTH-1:0] cmd_data,
  input  logic                            accept,
  input  logic                            stall,
  output logic                            run_c,
  output logic [WORD_WIDTH-1:0]           cin_word,
  output logic                            frame_active
);

  localparam int unsigned CNT_W = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CMD_WORDS - 1);

  cin_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [WORD_WIDTH-1:0] words [CMD_WORDS];

  assign run_c = (state == S_RUN);

  function automatic logic [WORD_WIDTH-1:0] mode_word(input logic [1:0] m);
    return (m == MODE_TRAIN) ? TRAIN_PATTERN : IDLE_WORD;
  endfunction

`ifdef CIN_FRAME_PARITY_EN
  logic [WORD_WIDTH-1:0] parity_c;

  always_comb begin
    parity_c = HDR_WORD;
    for (int i = 0; i < int'(CMD_WORDS); i++) parity_c = parity_c ^ words[i];
  end
`endif

  // Output word is registered together with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cin_word     <= IDLE_WORD;
      frame_active <= 1'b0;
      for (int i = 0; i < int'(CMD_WORDS); i++) words[i] <= '0;
    end else if (stall) begin
      cin_word <= SYNC_WORD;
    end else begin
      case (state)
        S_IDLE, S_TRAIN, S_RUN: begin
          if (accept) begin
            state        <= S_HDR;
            cin_word     <= HDR_WORD;
            frame_active <= 1'b1;
            for (int i = 0; i < int'(CMD_WORDS); i++)
              words[i] <= cmd_data[(int'(CMD_WORDS) - 1 - i)*int'(WORD_WIDTH) +: WORD_WIDTH];
          end else begin
            state        <= mode_state(mode);
            cin_word     <= mode_word(mode);
            frame_active <= 1'b0;
          end
        end
        S_HDR: begin
          state    <= S_DATA;
          cnt      <= '0;
          cin_word <= words[0];
        end
        S_DATA: begin
          if (cnt == LAST) begin
`ifdef CIN_FRAME_PARITY_EN
            state    <= S_PAR;
            cin_word <= parity_c;
`else
            state        <= mode_state(mode);
            cin_word     <= mode_word(mode);
            frame_active <= 1'b0;
`endif
          end else begin
            cnt      <= CNT_W'(cnt + 1'b1);
            cin_word <= words[CNT_W'(cnt + 1'b1)];
          end
        end
`ifdef CIN_FRAME_PARITY_EN
        S_PAR: begin
          state        <= mode_state(mode);
          cin_word     <= mode_word(mode);
          frame_active <= 1'b0;
        end
`endif
        default: begin
          state        <= S_IDLE;
          cin_word     <= IDLE_WORD;
          frame_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/surf_cin_framer.sv
// TURFIO->SURF CIN command-word generator: NSURF channels plus a global delayed SYNC.
// Define CIN_FRAME_PARITY_EN to append a parity word to each command frame.
module surf_cin_framer
  import surf_cin_pkg::*;
#(
  parameter int unsigned NSURF      = 1,
  parameter int unsigned WORD_WIDTH = 6,
  parameter int unsigned CMD_WORDS  = 4,
  parameter logic [WORD_WIDTH-1:0] TRAIN_PATTERN = WORD_WIDTH'(DEF_TRAIN_PATTERN),
  parameter logic [WORD_WIDTH-1:0] IDLE_WORD     = WORD_WIDTH'(DEF_IDLE_WORD),
  parameter logic [WORD_WIDTH-1:0] HDR_WORD      = WORD_WIDTH'(DEF_HDR_WORD),
  parameter logic [WORD_WIDTH-1:0] SYNC_WORD     = WORD_WIDTH'(DEF_SYNC_WORD),
  parameter int unsigned SYNC_DELAY = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [2*NSURF-1:0]                    mode,
  input  logic [NSURF*CMD_WORDS*WORD_WIDTH-1:0] cmd_data,
  input  logic [NSURF-1:0]                      cmd_valid,
  output logic [NSURF-1:0]                      cmd_ready,
  input  logic                                  sync_req,
  output logic                                  sync_busy,
  output logic [NSURF*WORD_WIDTH-1:0]           cin_word,
  output logic [NSURF-1:0]                      frame_active
);

  localparam int unsigned PW    = CMD_WORDS * WORD_WIDTH;
  localparam int unsigned SCW   = 8;

  logic [SCW-1:0] sync_cnt;
  logic           sync_emit;
  logic           sync_stall_c;

  // Stall decided one cycle ahead so the registered SYNC_WORD lands SYNC_DELAY+1 after the request.
  assign sync_stall_c = sync_busy && (sync_cnt == '0) && !sync_emit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_cnt  <= '0;
      sync_busy <= 1'b0;
      sync_emit <= 1'b0;
    end else begin
      sync_emit <= sync_stall_c;
      if (sync_emit) begin
        sync_busy <= 1'b0;
      end else if (!sync_busy && sync_req) begin
        sync_busy <= 1'b1;
        sync_cnt  <= SCW'(SYNC_DELAY - 1);
      end else if (sync_busy && sync_cnt != '0) begin
        sync_cnt <= SCW'(sync_cnt - 1'b1);
      end
    end
  end

  for (genvar c = 0; c < NSURF; c++) begin : g_chan
    logic run_c;

    assign cmd_ready[c] = run_c && (mode[2*c +: 2] == MODE_RUN) && !sync_stall_c;

    surf_cin_chan #(
      .WORD_WIDTH    (WORD_WIDTH),
      .CMD_WORDS     (CMD_WORDS),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .IDLE_WORD     (IDLE_WORD),
      .HDR_WORD      (HDR_WORD),
      .SYNC_WORD     (SYNC_WORD)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .mode         (mode[2*c +: 2]),
      .cmd_data     (cmd_data[c*PW +: PW]),
      .accept       (cmd_valid[c] && cmd_ready[c]),
      .stall        (sync_stall_c),
      .run_c        (run_c),
      .cin_word     (cin_word[c*WORD_WIDTH +: WORD_WIDTH]),
      .frame_active (frame_active[c])
    );
  end

endmodule
